// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 receive path.
//   ps2_state_t : receiver FSM states
//   FRAME_BITS  : start + 8 data + parity + stop
//   SC_*        : scan codes used by the keyboard front end
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_7E    = 8'h7E;
    localparam logic [7:0] SC_77    = 8'h77;
    localparam logic [7:0] SC_58    = 8'h58;

endpackage

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if -- keyboard lines in, decoded byte stream out.
//   ps2_clk, ps2_data : raw asynchronous PS/2 lines
//   check_code        : last accepted byte
//   code_new_updated  : one-cycle strobe for a new check_code
//   frame_error       : one-cycle strobe for a rejected/timed-out frame
//   busy              : receiver is mid-frame
// slave = receiver side, master = keyboard/host side.
interface ps2_rx_frame_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] check_code;
    logic       code_new_updated;
    logic       frame_error;
    logic       busy;

    modport slave (
        input  ps2_clk, ps2_data,
        output check_code, code_new_updated, frame_error, busy
    );

    modport master (
        output ps2_clk, ps2_data,
        input  check_code, code_new_updated, frame_error, busy
    );
endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter -- brings both PS/2 lines into the clk_2 domain, debounces
// the clock line and emits a one-cycle fall_evt on each filtered falling edge.
//   clk_2, rst            : system clock, synchronous active-high reset
//   ps2_clk_in/ps2_data_in: raw asynchronous lines
//   fall_evt              : filtered ps2_clk high-to-low strobe
//   data_s                : synchronised ps2_data, valid to sample with fall_evt
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_2,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic fall_evt,
    output logic data_s
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_2) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            cnt      <= '0;
            fall_evt <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
            fall_evt <= 1'b0;
            // cnt tracks how many consecutive cycles the line has disagreed
            // with the filtered level; any agreement restarts the run.
            if (clk_sync[1] != filt) begin
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    filt     <= clk_sync[1];
                    cnt      <= '0;
                    fall_evt <= filt;   // flipping away from 1 is a fall
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Data is only synchronised; it is held stable by the keyboard for far
    // longer than the filter latency around each clock fall.
    assign data_s = dat_sync[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 keyboard frame receiver (start, 8 data LSB first,
// parity, stop).
//   clk_2 : system clock       rst : synchronous active-high reset
//   bus   : ps2_rx_frame_if.slave (raw lines in, byte/strobes/busy out)
// Build option: define PS2_RX_PARITY_CHECK_EN to enforce odd parity;
// otherwise the parity bit is sampled and ignored.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           clk_2,
    input  logic           rst,
    ps2_rx_frame_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS);

    logic           fall_evt;
    logic           data_s;
    ps2_state_t     state;
    logic [BW-1:0]  bit_cnt;
    logic [7:0]     shreg;
    logic [TW-1:0]  tmo_cnt;
    logic           parity_ok;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk_2       (clk_2),
        .rst         (rst),
        .ps2_clk_in  (bus.ps2_clk),
        .ps2_data_in (bus.ps2_data),
        .fall_evt    (fall_evt),
        .data_s      (data_s)
    );

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_bit;
    // Odd parity across data plus parity bit.
    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state                <= IDLE;
            bit_cnt              <= '0;
            shreg                <= '0;
            tmo_cnt              <= '0;
            bus.check_code       <= 8'h00;
            bus.code_new_updated <= 1'b0;
            bus.frame_error      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_bit              <= 1'b0;
`endif
        end else begin
            bus.code_new_updated <= 1'b0;
            bus.frame_error      <= 1'b0;

            if (state == IDLE || fall_evt) tmo_cnt <= '0;
            else                           tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    // A high bit here is line noise, not a start bit.
                    if (fall_evt && !data_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                DATA: begin
                    if (fall_evt) begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall_evt) begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        par_bit <= data_s;
`endif
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (fall_evt) begin
                        state <= IDLE;
                        if (data_s && parity_ok) begin
                            bus.check_code       <= shreg;
                            bus.code_new_updated <= 1'b1;
                        end else begin
                            bus.frame_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A stalled keyboard must not wedge the receiver; a fall in the
            // expiry cycle wins and the frame carries on.
            if (state != IDLE && !fall_evt &&
                tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state           <= IDLE;
                bus.frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed scenarios plus randomized
// frames compared against a frame-level accept/reject model.
module tb_ps2_rx_frame;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 4096;
    localparam int HALF       = 30;     // clk_2 cycles per PS/2 half period

    logic clk_2 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_2 = ~clk_2;

    ps2_rx_frame_if bus ();

    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_2 (clk_2),
        .rst   (rst),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // Pulse observation
    logic [7:0] code_q[$];
    int         err_n     = 0;
    int         both_seen = 0;
    logic [7:0] exp_code  = 8'h00;

    always @(negedge clk_2) begin
        if (bus.code_new_updated) code_q.push_back(bus.check_code);
        if (bus.frame_error) err_n++;
        if (bus.code_new_updated && bus.frame_error) both_seen++;
    end

    // Reference model: a frame is accepted iff stop is 1 and, when parity
    // checking is built in, the 9 bits carry an odd number of ones.
    function automatic bit frame_ok(input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = $countones(d) + (p ? 1 : 0);
`ifdef PS2_RX_PARITY_CHECK_EN
        return s && (ones % 2 == 1);
`else
        if (ones < 0) return 1'b0;
        return s;
`endif
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_2);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_cyc(HALF / 2);
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        bus.ps2_data = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(4);
        @(negedge clk_2);
        total++;
        if (bus.check_code !== 8'h00 || bus.code_new_updated !== 1'b0 ||
            bus.frame_error !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset: code=%h new=%b err=%b busy=%b want 00/0/0/0",
                     bus.check_code, bus.code_new_updated, bus.frame_error, bus.busy);
        else passed++;
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_frame_7e;
        int e0;
        e0 = err_n; code_q.delete();
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_cyc(20);
        exp_code = 8'h7E;
        total++;
        if (code_q.size() !== 1 || err_n - e0 !== 0)
            $display("FAIL frame_7e_pulses: codes=%0d errs=%0d want 1/0", code_q.size(), err_n - e0);
        else passed++;
        total++;
        if (bus.check_code !== exp_code)
            $display("FAIL frame_7e_code: got %h want %h", bus.check_code, exp_code);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int e0;
        e0 = err_n; code_q.delete();
        send_frame(8'h58, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        wait_cyc(20);
        exp_code = 8'hF0;
        total++;
        if (code_q.size() !== 2 || err_n - e0 !== 0)
            $display("FAIL b2b_pulses: codes=%0d errs=%0d want 2/0", code_q.size(), err_n - e0);
        else passed++;
        total++;
        if (code_q.size() != 2 || code_q[0] !== 8'h58 || code_q[1] !== 8'hF0)
            $display("FAIL b2b_order: size=%0d first=%h second=%h want 58,f0", code_q.size(),
                     code_q.size() > 0 ? code_q[0] : 8'hxx, code_q.size() > 1 ? code_q[1] : 8'hxx);
        else passed++;
    endtask

    task automatic test_parity;
        int e0; bit ok;
        e0 = err_n; code_q.delete();
        ok = frame_ok(8'h58, 1'b1, 1'b1);
        send_frame(8'h58, 1'b1, 1'b1);
        wait_cyc(20);
        if (ok) exp_code = 8'h58;
        total++;
        if (code_q.size() !== (ok ? 1 : 0) || err_n - e0 !== (ok ? 0 : 1))
            $display("FAIL parity_pulses: codes=%0d errs=%0d want %0d/%0d",
                     code_q.size(), err_n - e0, ok ? 1 : 0, ok ? 0 : 1);
        else passed++;
        total++;
        if (bus.check_code !== exp_code)
            $display("FAIL parity_code: got %h want %h", bus.check_code, exp_code);
        else passed++;
    endtask

    task automatic test_timeout;
        int e0, k;
        e0 = err_n; code_q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(negedge clk_2);
        total++;
        if (bus.busy !== 1'b1) $display("FAIL timeout_busy_mid: got %b want 1", bus.busy);
        else passed++;
        k = 0;
        while (bus.busy === 1'b1 && k < TIMEOUT + 200) begin
            @(negedge clk_2);
            k++;
        end
        wait_cyc(3);
        total++;
        if (bus.busy !== 1'b0 || k < TIMEOUT - 2 * HALF || k > TIMEOUT)
            $display("FAIL timeout_expiry: busy=%b after %0d cycles want 0 within [%0d,%0d]",
                     bus.busy, k, TIMEOUT - 2 * HALF, TIMEOUT);
        else passed++;
        total++;
        if (err_n - e0 !== 1 || code_q.size() !== 0)
            $display("FAIL timeout_err: errs=%0d codes=%0d want 1/0", err_n - e0, code_q.size());
        else passed++;
        e0 = err_n;
        send_frame(8'h77, odd_par(8'h77), 1'b1);
        wait_cyc(20);
        exp_code = 8'h77;
        total++;
        if (bus.check_code !== exp_code || code_q.size() !== 1 || err_n !== e0)
            $display("FAIL timeout_recover: code=%h codes=%0d want %h/1",
                     bus.check_code, code_q.size(), exp_code);
        else passed++;
    endtask

    task automatic test_glitch;
        int e0, busy_seen;
        e0 = err_n; code_q.delete(); busy_seen = 0;
        bus.ps2_data = 1'b0;
        @(posedge clk_2);
        bus.ps2_clk = 1'b0;
        wait_cyc(3);
        bus.ps2_clk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_2);
            if (bus.busy !== 1'b0) busy_seen++;
        end
        bus.ps2_data = 1'b1;
        total++;
        if (busy_seen != 0 || err_n !== e0 || code_q.size() !== 0)
            $display("FAIL glitch: busy_cycles=%0d errs=%0d codes=%0d want 0/0/0",
                     busy_seen, err_n - e0, code_q.size());
        else passed++;
    endtask

    task automatic test_reset_midframe;
        int e0;
        e0 = err_n; code_q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk_2);
        rst = 1'b1;
        wait_cyc(3);
        @(negedge clk_2);
        exp_code = 8'h00;
        total++;
        if (bus.check_code !== 8'h00 || bus.busy !== 1'b0 || bus.frame_error !== 1'b0 ||
            bus.code_new_updated !== 1'b0)
            $display("FAIL midreset_state: code=%h busy=%b err=%b new=%b want 00/0/0/0",
                     bus.check_code, bus.busy, bus.frame_error, bus.code_new_updated);
        else passed++;
        rst = 1'b0;
        wait_cyc(10);
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_cyc(20);
        exp_code = 8'h7E;
        total++;
        if (err_n !== e0 || code_q.size() !== 1 || bus.check_code !== exp_code)
            $display("FAIL midreset_recover: errs=%0d codes=%0d code=%h want 0/1/%h",
                     err_n - e0, code_q.size(), bus.check_code, exp_code);
        else passed++;
    endtask

    task automatic test_random;
        logic [7:0] d; logic p, s; bit ok; int e0;
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            p = odd_par(d) ^ ($urandom_range(3) == 0);
            s = ($urandom_range(4) != 0);
            ok = frame_ok(d, p, s);
            e0 = err_n; code_q.delete();
            send_frame(d, p, s);
            wait_cyc(20);
            if (ok) exp_code = d;
            total++;
            if (code_q.size() !== (ok ? 1 : 0) || err_n - e0 !== (ok ? 0 : 1) ||
                bus.check_code !== exp_code)
                $display("FAIL random[%0d]: d=%h p=%b s=%b codes=%0d errs=%0d code=%h want %0d/%0d/%h",
                         n, d, p, s, code_q.size(), err_n - e0, bus.check_code,
                         ok ? 1 : 0, ok ? 0 : 1, exp_code);
            else passed++;
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_frame_7e();
        test_back_to_back();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        total++;
        if (both_seen !== 0)
            $display("FAIL exclusive_strobes: %0d overlapping cycles want 0", both_seen);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
